// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: start, 7 data bits LSB first, even parity, stop.
// Samples mid-bit from a free-running baud counter and holds the last good character.
module rx_serial_7e1 #(
  parameter int M = 434,
  parameter int N = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       dado_serial,
  input  logic       recebe_dado,
  output logic [6:0] dados_ascii,
  output logic       paridade_ok,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_frame,
  output logic       db_tick,
  output logic       db_dado_serial,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL        = 4'd0,
    VERIFICA_START = 4'd1,
    ESPERA         = 4'd2,
    AMOSTRA        = 4'd3,
    ESPERA_STOP    = 4'd4,
    VERIFICA_STOP  = 4'd5,
    ARMAZENA       = 4'd6,
    ERRO_FRAME     = 4'd7
  } estado_t;

  localparam logic [N-1:0] CNT_LAST = N'(M - 1);
  localparam logic [N-1:0] CNT_MEIO = N'(M / 2 - 1);

  estado_t      estado_q, estado_d;
  logic         sync1_q, sync2_q;
  logic [N-1:0] cnt_q, cnt_d;
  logic [3:0]   bcnt_q, bcnt_d;
  logic [7:0]   shift_q, shift_d;
  logic [6:0]   dados_q, dados_d;
  logic         par_q, par_d;
  logic         pronto_q, pronto_d;
  logic         tem_q, tem_d;
  logic         erro_q, erro_d;
  logic         s, tick, meio;

  assign s    = sync2_q;
  assign tick = (cnt_q == CNT_LAST);
  assign meio = (cnt_q == CNT_MEIO);

  // Synchronizer flops reset high so leaving reset never looks like a start bit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      estado_q <= INICIAL;
      cnt_q    <= '0;
      bcnt_q   <= '0;
      shift_q  <= '0;
      dados_q  <= '0;
      par_q    <= 1'b0;
      pronto_q <= 1'b0;
      tem_q    <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      sync1_q  <= dado_serial;
      sync2_q  <= sync1_q;
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      bcnt_q   <= bcnt_d;
      shift_q  <= shift_d;
      dados_q  <= dados_d;
      par_q    <= par_d;
      pronto_q <= pronto_d;
      tem_q    <= tem_d;
      erro_q   <= erro_d;
    end
  end

  always_comb begin
    estado_d = estado_q;
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    dados_d  = dados_q;
    par_d    = par_q;
    pronto_d = 1'b0;
    erro_d   = 1'b0;
    tem_d    = recebe_dado ? 1'b0 : tem_q;

    case (estado_q)
      INICIAL: begin
        if (!s) begin
          estado_d = VERIFICA_START;
          cnt_d    = '0;
        end
      end
      VERIFICA_START: begin
        if (meio) begin
          if (!s) begin
            estado_d = ESPERA;
            cnt_d    = '0;
            bcnt_d   = '0;
          end else begin
            estado_d = INICIAL;
          end
        end
      end
      ESPERA: begin
        if (tick) estado_d = AMOSTRA;
      end
      // Counter keeps running through the sample so bit spacing stays exactly M.
      AMOSTRA: begin
        shift_d  = {s, shift_q[7:1]};
        bcnt_d   = bcnt_q + 4'd1;
        estado_d = (bcnt_q == 4'd7) ? ESPERA_STOP : ESPERA;
      end
      ESPERA_STOP: begin
        if (tick) estado_d = VERIFICA_STOP;
      end
      VERIFICA_STOP: begin
        if (s) begin
          estado_d = ARMAZENA;
        end else begin
          estado_d = ERRO_FRAME;
          erro_d   = 1'b1;
        end
      end
      ARMAZENA: begin
        dados_d  = shift_q[6:0];
        par_d    = ~(^shift_q);
        tem_d    = 1'b1;
        pronto_d = 1'b1;
        estado_d = INICIAL;
      end
      ERRO_FRAME: begin
        if (s) estado_d = INICIAL;
      end
      default: estado_d = INICIAL;
    endcase
  end

  assign dados_ascii    = dados_q;
  assign paridade_ok    = par_q;
  assign pronto         = pronto_q;
  assign tem_dado       = tem_q;
  assign erro_frame     = erro_q;
  assign db_tick        = tick;
  assign db_dado_serial = sync2_q;
  assign db_estado      = estado_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed bench for rx_serial_7e1: a table of clean frames plus glitch,
// framing-error, back-to-back/acknowledge and mid-frame reset sequences.
module tb_rx_serial_7e1;

  localparam int M   = 434;
  localparam int N   = 9;
  localparam int NOM = M / 2 + 9 * M;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dado_serial = 1'b1;
  logic       recebe_dado = 1'b0;
  logic [6:0] dados_ascii;
  logic       paridade_ok, pronto, tem_dado, erro_frame;
  logic       db_tick, db_dado_serial;
  logic [3:0] db_estado;

  rx_serial_7e1 #(.M(M), .N(N)) dut (
    .clock(clock), .reset(reset), .dado_serial(dado_serial), .recebe_dado(recebe_dado),
    .dados_ascii(dados_ascii), .paridade_ok(paridade_ok), .pronto(pronto),
    .tem_dado(tem_dado), .erro_frame(erro_frame), .db_tick(db_tick),
    .db_dado_serial(db_dado_serial), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, pronto_cnt = 0, erro_cnt = 0, pronto_cyc = 0, overlap = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (pronto) begin
      pronto_cnt <= pronto_cnt + 1;
      pronto_cyc <= cyc;
    end
    if (erro_frame) erro_cnt <= erro_cnt + 1;
    if (pronto && erro_frame) overlap <= overlap + 1;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [6:0] d;
    logic       p;
    logic       exp_ok;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic stop,
                            output int s_cyc);
    logic [9:0] b;
    b = {stop, p, d, 1'b0};
    s_cyc = cyc;
    for (int k = 0; k < 10; k++) begin
      dado_serial = b[k];
      idle(M);
    end
    dado_serial = 1'b1;
  endtask

  task automatic wait_pronto(input int limit, output logic got);
    got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clock);
      if (pronto) got = 1'b1;
    end
  endtask

  initial begin
    int s_cyc, s2, p0, e0, lat;
    logic got;
    logic [6:0] last_d;
    logic [9:0] b;

    vecs[0] = '{7'h41, 1'b0, 1'b1};
    vecs[1] = '{7'h43, 1'b0, 1'b0};
    vecs[2] = '{7'h00, 1'b0, 1'b1};
    vecs[3] = '{7'h7F, 1'b0, 1'b0};
    vecs[4] = '{7'h7F, 1'b1, 1'b1};
    vecs[5] = '{7'h5A, 1'b0, 1'b1};

    idle(3);
    chk("rst_dados", dados_ascii, 0);
    chk("rst_par", paridade_ok, 0);
    chk("rst_pronto", pronto, 0);
    chk("rst_tem", tem_dado, 0);
    chk("rst_erro", erro_frame, 0);
    chk("rst_estado", db_estado, 0);
    chk("rst_sync", db_dado_serial, 1);
    reset = 1'b1;
    idle(5);

    for (int i = 0; i < 6; i++) begin
      p0 = pronto_cnt; e0 = erro_cnt;
      send_frame(vecs[i].d, vecs[i].p, 1'b1, s_cyc);
      idle(20);
      chk("vec_dados", dados_ascii, vecs[i].d);
      chk("vec_par_ok", paridade_ok, vecs[i].exp_ok);
      chk("vec_pronto_pulses", pronto_cnt - p0, 1);
      chk("vec_erro_pulses", erro_cnt - e0, 0);
      chk("vec_tem", tem_dado, 1);
      lat = pronto_cyc - s_cyc - 3;
      n_checks++;
      if (lat < NOM - 2 || lat > NOM + 3) begin
        n_fail++;
        $display("FAIL vec_latency: got %0d cycles, required %0d..%0d", lat, NOM - 2, NOM + 3);
      end
      recebe_dado = 1'b1; idle(1); recebe_dado = 1'b0; idle(1);
      chk("vec_ack_clears", tem_dado, 0);
    end
    last_d = vecs[5].d;

    // Short low glitch: start rejected at mid-bit.
    p0 = pronto_cnt; e0 = erro_cnt;
    dado_serial = 1'b0; idle(50);
    chk("glitch_in_verify", db_estado, 1);
    idle(50); dado_serial = 1'b1; idle(300);
    chk("glitch_estado", db_estado, 0);
    chk("glitch_pronto", pronto_cnt - p0, 0);
    chk("glitch_erro", erro_cnt - e0, 0);
    chk("glitch_dados", dados_ascii, last_d);
    chk("glitch_tem", tem_dado, 0);

    // Stop bit low for 2M: framing error, hold in state 7 until line high.
    p0 = pronto_cnt; e0 = erro_cnt;
    send_frame(7'h30, 1'b0, 1'b0, s_cyc);
    dado_serial = 1'b0; idle(M);
    chk("ferr_estado7", db_estado, 7);
    chk("ferr_erro_pulses", erro_cnt - e0, 1);
    chk("ferr_pronto", pronto_cnt - p0, 0);
    dado_serial = 1'b1; idle(10);
    chk("ferr_back_idle", db_estado, 0);
    chk("ferr_dados", dados_ascii, last_d);
    chk("ferr_tem", tem_dado, 0);

    // Back-to-back frames, ack between them, ack held over the second store.
    p0 = pronto_cnt;
    fork
      begin
        send_frame(7'h55, 1'b0, 1'b1, s_cyc);
        send_frame(7'h2A, 1'b1, 1'b1, s2);
      end
      begin
        wait_pronto(2 * NOM, got);
        chk("b2b_first_seen", got, 1);
        chk("b2b_first_dados", dados_ascii, 7'h55);
        chk("b2b_first_par", paridade_ok, 1);
        chk("b2b_first_tem", tem_dado, 1);
        idle(10);
        recebe_dado = 1'b1; idle(1); recebe_dado = 1'b0; idle(1);
        chk("b2b_ack_clears", tem_dado, 0);
        recebe_dado = 1'b1;
        wait_pronto(2 * NOM, got);
        recebe_dado = 1'b0;
        chk("b2b_second_seen", got, 1);
        chk("b2b_set_wins", tem_dado, 1);
        chk("b2b_second_dados", dados_ascii, 7'h2A);
        chk("b2b_second_par", paridade_ok, 1);
      end
    join
    idle(20);
    chk("b2b_pronto_count", pronto_cnt - p0, 2);
    chk("b2b_tem_held", tem_dado, 1);

    // Reset asserted in the middle of data bit 3.
    b = {1'b1, 1'b0, 7'h41, 1'b0};
    for (int k = 0; k < 4; k++) begin
      dado_serial = b[k];
      idle(M);
    end
    dado_serial = b[4];
    idle(M / 2);
    reset = 1'b0;
    #1;
    chk("mrst_dados", dados_ascii, 0);
    chk("mrst_par", paridade_ok, 0);
    chk("mrst_tem", tem_dado, 0);
    chk("mrst_estado", db_estado, 0);
    chk("mrst_sync", db_dado_serial, 1);
    dado_serial = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(M);
    p0 = pronto_cnt;
    send_frame(7'h7F, 1'b1, 1'b1, s_cyc);
    idle(20);
    chk("post_rst_dados", dados_ascii, 7'h7F);
    chk("post_rst_par", paridade_ok, 1);
    chk("post_rst_tem", tem_dado, 1);
    chk("post_rst_pronto", pronto_cnt - p0, 1);

    chk("pronto_erro_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
